// File: rtl/seven_seg_driver.sv
// seven_seg_driver
//   Drives a 3-digit multiplexed seven-segment display from the one-hot scan
//   enable of the digit scanner. Every enable change blanks all digits for
//   DEAD_CLK cycles to avoid ghosting. The segment path muxes the active BCD
//   digit, decodes it and applies the per-digit blink mask.
//
// Optional build macro:
//   SEVEN_SEG_LZB_EN  leading-zero blanking of digits 2 and 1
//
// Ports:
//   i_clk         system clock
//   rst_n         asynchronous active-low reset
//   i_digit_en    one-hot scan enable, bit k selects digit k (digit 0 = LSD)
//   i_bcd         digit values, digit k = i_bcd[4k+3:4k]
//   i_dp          decimal point request per digit
//   i_blink_mask  digits to blink
//   o_seg         segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   o_dp          decimal point, polarity per SEG_ACTIVE_LOW
//   o_digit       registered digit drive, polarity per DIG_ACTIVE_LOW
//
// FSM states:
//   state    | meaning
//   ST_BLANK | all digits off; dead-time count running or enable not one-hot
//   ST_DRIVE | digit selected by en_q is driven
module seven_seg_driver #(
  parameter int unsigned DEAD_CLK       = 4,
  parameter logic [23:0] BLINK_HALF     = 24'd6_000_000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
  input  logic        i_clk,
  input  logic        rst_n,
  input  logic [2:0]  i_digit_en,
  input  logic [11:0] i_bcd,
  input  logic [2:0]  i_dp,
  input  logic [2:0]  i_blink_mask,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic [2:0]  o_digit
);

  localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CLK);
  localparam logic [6:0] SEG_OFF   = {7{SEG_ACTIVE_LOW}};
  localparam logic       DP_OFF    = SEG_ACTIVE_LOW;
  localparam logic [2:0] DIG_OFF   = {3{DIG_ACTIVE_LOW}};

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  dead_q, dead_d;
  logic [2:0]  en_q;
  logic [2:0]  digit_d;
  logic        change;

  logic [23:0] blink_cnt;
  logic        blink_phase;

  logic [3:0]  sel_bcd;
  logic        sel_dp;
  logic        sel_mask;
  logic        sel_lzb;
  logic        sel_valid;
  logic        seg_blank;
  logic [2:0]  lzb;

  function automatic logic is_onehot(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  // Active-high pattern {g,f,e,d,c,b,a}; non-decimal codes show '-'.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] p;
    p = 7'b1000000;
    case (v)
      4'd0: p = 7'b0111111;
      4'd1: p = 7'b0000110;
      4'd2: p = 7'b1011011;
      4'd3: p = 7'b1001111;
      4'd4: p = 7'b1100110;
      4'd5: p = 7'b1101101;
      4'd6: p = 7'b1111101;
      4'd7: p = 7'b0000111;
      4'd8: p = 7'b1111111;
      4'd9: p = 7'b1101111;
      default: p = 7'b1000000;
    endcase
    return p;
  endfunction

  assign change = (i_digit_en != en_q);

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BLANK;
      dead_q  <= DEAD_LOAD;
      en_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      dead_q  <= dead_d;
      en_q    <= i_digit_en;
    end
  end

  always_comb begin
    state_d = state_q;
    dead_d  = dead_q;
    if (change) begin
      dead_d = DEAD_LOAD;
      // Without dead time the new digit is driven straight away (no gap).
      if ((DEAD_CLK == 0) && is_onehot(i_digit_en)) state_d = ST_DRIVE;
      else                                          state_d = ST_BLANK;
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (dead_q != 8'd0)     dead_d  = dead_q - 8'd1;
          else if (is_onehot(en_q)) state_d = ST_DRIVE;
        end
        ST_DRIVE: begin
          if (!is_onehot(en_q)) state_d = ST_BLANK;
        end
        default: state_d = ST_BLANK;
      endcase
    end
  end

  // Registered from the next state so the blank lands on the change edge.
  // In ST_DRIVE without a change, i_digit_en equals en_q.
  assign digit_d = (state_d == ST_DRIVE) ? i_digit_en : 3'b000;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) o_digit <= DIG_OFF;
    else        o_digit <= digit_d ^ DIG_OFF;
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= 24'd0;
      blink_phase <= 1'b1;
    end else if (BLINK_HALF == 24'd0) begin
      blink_cnt   <= 24'd0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BLINK_HALF - 24'd1) begin
      blink_cnt   <= 24'd0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 24'd1;
    end
  end

`ifdef SEVEN_SEG_LZB_EN
  // Digit 1 may only hide when digit 2 is hidden too.
  assign lzb[2] = (i_bcd[11:8] == 4'd0) && !i_dp[2];
  assign lzb[1] = lzb[2] && (i_bcd[7:4] == 4'd0) && !i_dp[1];
  assign lzb[0] = 1'b0;
`else
  assign lzb = 3'b000;
`endif

  always_comb begin
    sel_valid = 1'b1;
    sel_bcd   = i_bcd[3:0];
    sel_dp    = i_dp[0];
    sel_mask  = i_blink_mask[0];
    sel_lzb   = lzb[0];
    case (en_q)
      3'b001: begin
        sel_bcd  = i_bcd[3:0];
        sel_dp   = i_dp[0];
        sel_mask = i_blink_mask[0];
        sel_lzb  = lzb[0];
      end
      3'b010: begin
        sel_bcd  = i_bcd[7:4];
        sel_dp   = i_dp[1];
        sel_mask = i_blink_mask[1];
        sel_lzb  = lzb[1];
      end
      3'b100: begin
        sel_bcd  = i_bcd[11:8];
        sel_dp   = i_dp[2];
        sel_mask = i_blink_mask[2];
        sel_lzb  = lzb[2];
      end
      default: sel_valid = 1'b0;
    endcase
  end

  assign seg_blank = !sel_valid || (!blink_phase && sel_mask) || sel_lzb;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_seg <= SEG_OFF;
      o_dp  <= DP_OFF;
    end else if (seg_blank) begin
      o_seg <= SEG_OFF;
      o_dp  <= DP_OFF;
    end else begin
      o_seg <= decode(sel_bcd) ^ SEG_OFF;
      o_dp  <= sel_dp ^ DP_OFF;
    end
  end

endmodule

// File: tb/tb_seven_seg_driver.sv
// tb_seven_seg_driver
//   Self-checking bench for seven_seg_driver (DEAD_CLK = 4, BLINK_HALF = 8,
//   active-low segments, active-high digits). Expected outputs come from a
//   reference model built on edge counts: a digit is lit once enough edges
//   have passed since the last enable change, blink phase is derived from the
//   edge number, and segment shapes are listed by segment letter.
//   Honours SEVEN_SEG_LZB_EN like the design.
module tb_seven_seg_driver;

  localparam int DEAD_CLK   = 4;
  localparam int BLINK_HALF = 8;
  localparam int NEED       = (DEAD_CLK == 0) ? 0 : DEAD_CLK + 1;

  logic        i_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  en    = 3'b000;
  logic [11:0] bcd   = 12'h000;
  logic [2:0]  dp    = 3'b000;
  logic [2:0]  mask  = 3'b000;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic [2:0]  o_digit;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          e        = 0;
  int          last_change = 0;
  logic [2:0]  en_prev  = 3'b000;

  string shapes [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                         "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  seven_seg_driver #(
    .DEAD_CLK       (DEAD_CLK),
    .BLINK_HALF     (24'd8),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b0)
  ) dut (
    .i_clk        (i_clk),
    .rst_n        (rst_n),
    .i_digit_en   (en),
    .i_bcd        (bcd),
    .i_dp         (dp),
    .i_blink_mask (mask),
    .o_seg        (o_seg),
    .o_dp         (o_dp),
    .o_digit      (o_digit)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [6:0] shape_bits(int v);
    string s;
    logic [6:0] b;
    b = 7'b0000000;
    s = (v <= 9) ? shapes[v] : "g";
    for (int i = 0; i < s.len(); i++) b[int'(s[i]) - 97] = 1'b1;
    return b;
  endfunction

  // Blink phase after edge ed: visible during even half-periods.
  function automatic bit phase_at(int ed);
    if (BLINK_HALF == 0) return 1'b1;
    return ((ed / BLINK_HALF) % 2) == 0;
  endfunction

  task automatic check(string what, logic [6:0] seg_e, logic dp_e, logic [2:0] dig_e);
    n_checks++;
    assert (o_seg === seg_e) else begin
      n_fail++;
      $error("FAIL %s seg edge %0d: observed %b expected %b", what, e, o_seg, seg_e);
    end
    n_checks++;
    assert (o_dp === dp_e) else begin
      n_fail++;
      $error("FAIL %s dp edge %0d: observed %b expected %b", what, e, o_dp, dp_e);
    end
    n_checks++;
    assert (o_digit === dig_e) else begin
      n_fail++;
      $error("FAIL %s digit edge %0d: observed %b expected %b", what, e, o_digit, dig_e);
    end
  endtask

  // One clock edge: update the model with the inputs seen at this edge,
  // then compare just after the edge.
  task automatic step(string what);
    logic [6:0] seg_e;
    logic       dp_e;
    logic [2:0] dig_e;
    int         k;
    bit         blank;
    @(posedge i_clk);
    e++;
    seg_e = 7'h7F;
    dp_e  = 1'b1;
    if ($countones(en_prev) == 1) begin
      k = 0;
      for (int i = 0; i < 3; i++) if (en_prev[i]) k = i;
      blank = !phase_at(e - 1) && mask[k];
`ifdef SEVEN_SEG_LZB_EN
      if (k == 2 && bcd[11:8] == 4'd0 && !dp[2]) blank = 1'b1;
      if (k == 1 && bcd[11:4] == 8'd0 && !dp[2] && !dp[1]) blank = 1'b1;
`endif
      if (!blank) begin
        seg_e = ~shape_bits(int'(bcd[4*k +: 4]));
        dp_e  = ~dp[k];
      end
    end
    if (en != en_prev) last_change = e;
    en_prev = en;
    dig_e = ($countones(en) == 1 && (e - last_change) >= NEED) ? en : 3'b000;
    #1;
    check(what, seg_e, dp_e, dig_e);
  endtask

  task automatic steps(string what, int n);
    for (int i = 0; i < n; i++) step(what);
  endtask

  initial begin
    int hold;
    en   = 3'b001;
    bcd  = 12'h123;
    dp   = 3'b000;
    mask = 3'b000;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset", 7'h7F, 1'b1, 3'b000);
    @(negedge i_clk);
    rst_n = 1'b1;

    steps("release", 6);
    n_checks++;
    assert (o_digit === 3'b001 && o_seg === 7'b0110000) else begin
      n_fail++;
      $error("FAIL release_literal: observed digit %b seg %b expected 001 0110000", o_digit, o_seg);
    end

    en = 3'b010;
    step("dead_time");
    step("dead_time");
    n_checks++;
    assert (o_seg === 7'b0100100 && o_digit === 3'b000) else begin
      n_fail++;
      $error("FAIL dead_literal: observed seg %b digit %b expected 0100100 000", o_seg, o_digit);
    end
    steps("dead_time", 5);

    en = 3'b001;
    steps("settle", 7);
    en = 3'b010;
    steps("mid_dead", 2);
    en = 3'b100;
    steps("mid_dead", 8);

    en = 3'b011;
    steps("invalid", 10);
    en = 3'b000;
    steps("invalid", 3);
    en = 3'b100;
    steps("invalid_exit", 7);

    bcd  = 12'h456;
    en   = 3'b001;
    mask = 3'b001;
    steps("blink_masked", 36);
    en = 3'b010;
    steps("blink_unmasked", 36);
    mask = 3'b000;

    bcd = 12'h007;
    for (int d = 0; d < 3; d++) begin
      en = 3'b001 << d;
      steps("lzb_007", 7);
    end
    bcd = 12'h070;
    for (int d = 0; d < 3; d++) begin
      en = 3'b001 << d;
      steps("lzb_070", 7);
    end
    dp = 3'b100;
    steps("lzb_dp", 3);
    dp = 3'b000;

    for (int r = 0; r < 350; r++) begin
      hold = $urandom_range(1, 12);
      if ($urandom_range(0, 4) == 0) en = 3'($urandom_range(0, 7));
      else                           en = 3'b001 << $urandom_range(0, 2);
      mask = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      for (int h = 0; h < hold; h++) begin
        bcd = 12'($urandom);
        if ($urandom_range(0, 3) == 0) bcd[11:4] = 8'h00;
        dp = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
        step("random");
      end
      if (r == 175) begin
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", 7'h7F, 1'b1, 3'b000);
        @(negedge i_clk);
        rst_n       = 1'b1;
        e           = 0;
        last_change = 0;
        en_prev     = 3'b000;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_driver.md
Name: seven_seg_driver

Overview:
- Downstream consumer of the 3-digit scan enable produced by the digit scanner in the clock display path.
- Selects the BCD value for the active digit, decodes it to segments, and drives registered segment and digit-enable outputs to the pins.
- Inserts a dead-time blank on every digit change to prevent ghosting.
- Applies a per-digit blink mask, used for the time-set mode.

Parameters:
- DEAD_CLK, 4, number of i_clk cycles all digits are held off after an enable change; 0..255; 0 = no dead time.
- BLINK_HALF, 24'd6_000_000, i_clk cycles per blink half-period; 0 disables blinking (always visible).
- SEG_ACTIVE_LOW, 1, 1 = segment and DP outputs are active-low, 0 = active-high.
- DIG_ACTIVE_LOW, 0, 1 = o_digit is active-low, 0 = active-high.

Ports:
- i_clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_digit_en  in  3  one-hot scan enable from the scanner; bit k selects digit k; digit 0 is least significant.
- i_bcd  in  12  digit values; digit k = i_bcd[4k+3:4k].
- i_dp  in  3  decimal point request per digit.
- i_blink_mask  in  3  digits to blink.
- o_seg  out  7  segments {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW.
- o_dp  out  1  decimal point, polarity set by SEG_ACTIVE_LOW.
- o_digit  out  3  registered digit drive, polarity set by DIG_ACTIVE_LOW.

Behaviour:
- Reset (asynchronous, rst_n low):
  - o_seg and o_dp are "off" (all 1 if SEG_ACTIVE_LOW, else 0).
  - o_digit is "off".
  - FSM = BLANK; dead counter = DEAD_CLK; en_q = 3'b000; blink counter = 0; blink phase = 1 (visible).
- en_q register samples i_digit_en every cycle. A change is defined as i_digit_en != en_q.
- FSM states:
  - BLANK: o_digit off; dead counter decrements each cycle. Go to DRIVE when the counter == 0 and en_q is valid one-hot.
  - DRIVE: o_digit = en_q (polarity-mapped).
  - Any state, on a change: enter BLANK and reload the counter with DEAD_CLK. A change during BLANK restarts the count.
  - en_q not one-hot (000, or two or more bits set): stay in BLANK; o_digit off.
- Timing for a change sampled at edge N:
  - o_digit off from N+1.
  - o_digit on at N+DEAD_CLK+1.
  - With DEAD_CLK = 0, o_digit follows i_digit_en with one cycle of latency and no gap.
- Segment path (registered, 1-cycle latency from en_q/i_bcd/i_dp):
  - Mux digit k, where k is the set bit of en_q.
  - Decode values 0-9 to the standard patterns (0 = a,b,c,d,e,f; 1 = b,c; ... 8 = all; 9 = a,b,c,d,f,g).
  - Decode values 10-15 to '-' (segment g only).
  - o_dp = i_dp[k].
  - A BCD change without an enable change updates o_seg next cycle with no dead time.
- Blink:
  - The counter counts 0..BLINK_HALF-1 and wraps; the phase toggles on each wrap.
  - While phase = 0 and i_blink_mask[k] = 1: o_seg and o_dp are off, but o_digit is still driven normally.
  - A mask change takes effect on the next segment register update.
  - BLINK_HALF = 0: counter held at 0, phase held at 1.
- Invalid en_q: o_seg and o_dp are off.

Optional Feature:
- Macro: SEVEN_SEG_LZB_EN.
- Defined (leading-zero blanking):
  - Digit 2 is blanked (segments and DP off) when bcd2 == 0 and i_dp[2] == 0.
  - Digit 1 is blanked when bcd2 == 0, bcd1 == 0, digit 2 is blanked, and i_dp[1] == 0.
  - Digit 0 is never blanked.
  - Blanking is evaluated combinationally from the current i_bcd and registered with the segment path.
- Undefined: all digits display their value, including zeros.

Test Plan:
- Reset values: hold rst_n = 0 → o_seg = 7'h7F, o_dp = 1, o_digit = 3'b000 (defaults). Release rst_n with i_digit_en = 3'b001 and i_bcd = 12'h123 → o_digit = 3'b001 after 5 cycles; o_seg = 7'b0110000 (digit 3 = a,b,c,d,g active-low → g,f,e,d,c,b,a = 0,1,1,0,0,0,0).
- Dead time: i_digit_en 001 → 010 at edge N (DEAD_CLK = 4) → o_digit = 000 for N+1..N+4 and 010 at N+5; o_seg shows '2' (7'b0100100) from N+1.
- Mid-dead-time change: i_digit_en 001 → 010 at N, then 010 → 100 at N+2 → o_digit off through N+6, 100 at N+7.
- Invalid enable: i_digit_en = 3'b011 → o_digit = 000 and o_seg = 7'h7F for as long as it is held. Return to 3'b100 → drive resumes after DEAD_CLK+1 cycles.
- Blink (BLINK_HALF = 8): i_blink_mask = 3'b001 with digit 0 active → o_seg alternates 8 cycles value / 8 cycles 7'h7F while o_digit stays 001. Digit 1 (unmasked) is never blanked.
- SEVEN_SEG_LZB_EN: i_bcd = 12'h007, i_dp = 0 → digits 2 and 1 show 7'h7F and digit 0 shows '7'. With i_bcd = 12'h070 → digit 1 shows '7' and digit 2 is blank.
